// File: rtl/bias_pingpong_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : bias_pingpong_buffer
//  Purpose  : Double-banked bias store. The weight bus fills one bank while
//             the compute array reads every lane of one entry from the other.
//             A swap handshake exchanges the banks once the fill bank is full.
//  Ports    :
//     clk, rst     - clock, asynchronous active-high reset
//     wr_en        - weight-bus write strobe
//     weight_addr  - weight-bus word address
//     weight_data  - write data
//     swap_req     - one-cycle swap request
//     swap_ack     - one-cycle pulse, swap performed
//     fill_full    - fill bank holds a complete set of accepted writes
//     active_vld   - active bank holds a committed bias set
//     rd_req       - read request
//     bias_addr    - entry index to read
//     bias_data    - all lanes of the entry, lane l at [l*W +: W]
//     bias_valid   - bias_data updated this cycle
//     addr_err     - sticky out-of-window write flag
//  Options  : define BIAS_PINGPONG_ADDR_CHK_EN to build the addr_err checker;
//             without it addr_err is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module bias_pingpong_buffer #(
   parameter int unsigned pWEIGHT_DATA_WIDTH = 64,
   parameter logic [31:0] pWEIGHT_BASE_ADDR  = 32'd4000_0000,
   parameter int unsigned pBIAS_NUM          = 32,
   parameter int unsigned pLANE_NUM          = 32
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      wr_en,
   input  logic [31:0]                               weight_addr,
   input  logic [pWEIGHT_DATA_WIDTH-1:0]             weight_data,
   input  logic                                      swap_req,
   output logic                                      swap_ack,
   output logic                                      fill_full,
   output logic                                      active_vld,
   input  logic                                      rd_req,
   input  logic [$clog2(pBIAS_NUM)-1:0]              bias_addr,
   output logic [pWEIGHT_DATA_WIDTH*pLANE_NUM-1:0]   bias_data,
   output logic                                      bias_valid,
   output logic                                      addr_err
);

   localparam int unsigned DW        = pWEIGHT_DATA_WIDTH;
   localparam int unsigned TOTAL     = pBIAS_NUM * pLANE_NUM;
   localparam int unsigned LANE_W    = $clog2(pLANE_NUM);
   localparam int unsigned ENTRY_W   = $clog2(pBIAS_NUM);
   localparam int unsigned CNT_W     = $clog2(TOTAL + 1);
   localparam logic [31:0] TOTAL_32  = 32'(TOTAL);
   localparam logic [CNT_W-1:0] TOTAL_CNT = CNT_W'(TOTAL);

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_FILLING = 2'd1,
      ST_FULL    = 2'd2
   } fill_state_t;

   // ---------------------------------------------------------------- decode
   logic [31:0]        wr_off;
   logic               wr_above_base;
   logic               wr_accept;
   logic [LANE_W-1:0]  wr_lane;
   logic [ENTRY_W-1:0] wr_entry;

   // The subtraction may wrap for addresses below BASE; wr_above_base masks
   // that case so the wrapped offset is never used.
   assign wr_off        = weight_addr - pWEIGHT_BASE_ADDR;
   assign wr_above_base = (weight_addr >= pWEIGHT_BASE_ADDR);
   assign wr_accept     = wr_en && wr_above_base && (wr_off < TOTAL_32);
   assign wr_lane       = wr_off[LANE_W-1:0];
   assign wr_entry      = wr_off[LANE_W +: ENTRY_W];

   // ---------------------------------------------------------------- state
   fill_state_t                 state_q, state_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        active_idx_q, active_idx_d;
   logic                        active_vld_q, active_vld_d;
   logic                        swap_ack_q, swap_ack_d;
   logic                        fill_full_q, fill_full_d;
   logic                        bias_valid_q, bias_valid_d;
   logic [DW*pLANE_NUM-1:0]     bias_data_q, bias_data_d;
   logic [DW*pLANE_NUM-1:0]     rd_word;
   logic                        swap_fire;

   // ---------------------------------------------------------------- storage
   // Index 0/1 is the physical bank; the fill bank is always ~active_idx_q.
   // Contents are deliberately not reset.
   logic [DW-1:0] bank_ram [2][pLANE_NUM][pBIAS_NUM];

   // A write in the swap cycle still uses the pre-swap fill bank, so it
   // lands in what becomes the active bank.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         bank_ram[~active_idx_q][wr_lane][wr_entry] <= weight_data;
      end
   end

   generate
      for (genvar l = 0; l < pLANE_NUM; l++) begin : g_lane
         assign rd_word[l*DW +: DW] = bank_ram[active_idx_q][l][bias_addr];
      end
   endgenerate

   // ---------------------------------------------------------------- next state
   assign swap_fire = swap_req && (state_q == ST_FULL);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      active_idx_d = active_idx_q;
      active_vld_d = active_vld_q;
      swap_ack_d   = 1'b0;

      if (swap_fire) begin
         // A concurrent accepted write is credited to the outgoing bank only.
         active_idx_d = ~active_idx_q;
         active_vld_d = 1'b1;
         cnt_d        = '0;
         state_d      = ST_EMPTY;
         swap_ack_d   = 1'b1;
      end else if (wr_accept) begin
         if (cnt_q != TOTAL_CNT) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         state_d = (cnt_d == TOTAL_CNT) ? ST_FULL : ST_FILLING;
      end

      fill_full_d  = (state_d == ST_FULL);

      // Read always targets the pre-swap active bank.
      bias_valid_d = rd_req && active_vld_q;
      bias_data_d  = bias_valid_d ? rd_word : bias_data_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_EMPTY;
         cnt_q        <= '0;
         active_idx_q <= 1'b0;
         active_vld_q <= 1'b0;
         swap_ack_q   <= 1'b0;
         fill_full_q  <= 1'b0;
         bias_valid_q <= 1'b0;
         bias_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         active_idx_q <= active_idx_d;
         active_vld_q <= active_vld_d;
         swap_ack_q   <= swap_ack_d;
         fill_full_q  <= fill_full_d;
         bias_valid_q <= bias_valid_d;
         bias_data_q  <= bias_data_d;
      end
   end

   assign swap_ack   = swap_ack_q;
   assign fill_full  = fill_full_q;
   assign active_vld = active_vld_q;
   assign bias_valid = bias_valid_q;
   assign bias_data  = bias_data_q;

   // ---------------------------------------------------------------- address check
`ifdef BIAS_PINGPONG_ADDR_CHK_EN
   logic addr_err_q, addr_err_d;

   // Addresses below BASE belong to other slaves and are ignored here.
   always_comb begin
      addr_err_d = addr_err_q | (wr_en && wr_above_base && (wr_off >= TOTAL_32));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_err_q <= 1'b0;
      end else begin
         addr_err_q <= addr_err_d;
      end
   end

   assign addr_err = addr_err_q;
`else
   assign addr_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bias_pingpong_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bias_pingpong_buffer
//  Purpose  : Self-checking bench for bias_pingpong_buffer (4 lanes x 8
//             entries x 16 bits). Reads are checked by a queue scoreboard
//             fed from a behavioural model of the two banks; status outputs
//             are compared against the model after every clock.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bias_pingpong_buffer;

   localparam logic [31:0] BASE  = 32'd4000_0000;
   localparam int          TOTAL = 32;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [31:0] weight_addr;
   logic [15:0] weight_data;
   logic        swap_req;
   logic        swap_ack;
   logic        fill_full;
   logic        active_vld;
   logic        rd_req;
   logic [2:0]  bias_addr;
   logic [63:0] bias_data;
   logic        bias_valid;
   logic        addr_err;

   bias_pingpong_buffer #(
      .pWEIGHT_DATA_WIDTH (16),
      .pWEIGHT_BASE_ADDR  (BASE),
      .pBIAS_NUM          (8),
      .pLANE_NUM          (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .weight_addr (weight_addr),
      .weight_data (weight_data),
      .swap_req    (swap_req),
      .swap_ack    (swap_ack),
      .fill_full   (fill_full),
      .active_vld  (active_vld),
      .rd_req      (rd_req),
      .bias_addr   (bias_addr),
      .bias_data   (bias_data),
      .bias_valid  (bias_valid),
      .addr_err    (addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model: each bank is a flat array indexed by word offset.
   logic [15:0] m_bank [2][TOTAL];
   int          m_cnt;
   bit          m_active;
   bit          m_vld;
   bit          m_err;
   bit          m_ack;
   logic [63:0] sb_q [$];
   logic [63:0] m_last;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // One clock of stimulus; model advances on the same edge; outputs checked #1 later.
   task automatic step(input bit wr, input logic [31:0] addr, input logic [15:0] data,
                       input bit swp, input bit rd, input logic [2:0] ba);
      logic [31:0] off;
      bit          acc;
      bit          fire;
      logic [63:0] e;
      wr_en       = wr;
      weight_addr = addr;
      weight_data = data;
      swap_req    = swp;
      rd_req      = rd;
      bias_addr   = ba;
      @(posedge clk);
      off  = addr - BASE;
      acc  = wr && (addr >= BASE) && (off < 32'(TOTAL));
      fire = swp && (m_cnt == TOTAL);
      if (rd && m_vld) begin
         e = '0;
         for (int l = 0; l < 4; l++) e[l*16 +: 16] = m_bank[m_active][int'(ba)*4 + l];
         sb_q.push_back(e);
      end
      if (acc) begin
         m_bank[!m_active][off] = data;
         if (!fire && m_cnt < TOTAL) m_cnt++;
      end
`ifdef BIAS_PINGPONG_ADDR_CHK_EN
      if (wr && (addr >= BASE) && (off >= 32'(TOTAL))) m_err = 1'b1;
`endif
      m_ack = fire;
      if (fire) begin
         m_active = !m_active;
         m_vld    = 1'b1;
         m_cnt    = 0;
      end
      #1;
      chk("swap_ack",   {63'd0, swap_ack},   {63'd0, m_ack});
      chk("fill_full",  {63'd0, fill_full},  {63'd0, (m_cnt == TOTAL)});
      chk("active_vld", {63'd0, active_vld}, {63'd0, m_vld});
      chk("addr_err",   {63'd0, addr_err},   {63'd0, m_err});
   endtask

   task automatic idle();
      step(1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 3'd0);
   endtask

   task automatic do_reset();
      wr_en = 1'b0; swap_req = 1'b0; rd_req = 1'b0;
      rst = 1'b1;
      m_cnt = 0; m_vld = 1'b0; m_active = 1'b0; m_err = 1'b0; m_ack = 1'b0;
      #2;
      chk("rst_fill_full",  {63'd0, fill_full},  64'd0);
      chk("rst_active_vld", {63'd0, active_vld}, 64'd0);
      chk("rst_swap_ack",   {63'd0, swap_ack},   64'd0);
      chk("rst_bias_valid", {63'd0, bias_valid}, 64'd0);
      chk("rst_addr_err",   {63'd0, addr_err},   64'd0);
      chk("rst_bias_data",  bias_data,           64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Fill offsets lo..hi with base_val+off, no read, no swap.
   task automatic fill_range(input int lo, input int hi, input logic [15:0] base_val);
      for (int i = lo; i <= hi; i++) step(1'b1, BASE + 32'(i), base_val + 16'(i), 1'b0, 1'b0, 3'd0);
   endtask

   // Scoreboard monitor: anything pushed at a rising edge must appear at the next falling edge.
   always @(negedge clk) begin
      if (rst) begin
         m_last = '0;
         sb_q.delete();
      end else begin
         if (bias_valid) begin
            if (sb_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL bias_valid_unexpected: got 1 expected 0 (t=%0t)", $time);
            end else begin
               logic [63:0] e;
               e = sb_q.pop_front();
               chk("bias_data", bias_data, e);
               m_last = e;
            end
         end else begin
            chk("bias_data_hold", bias_data, m_last);
            if (sb_q.size() != 0) begin
               n_cmp++; n_err++;
               $display("FAIL bias_valid_missing: got 0 expected 1 (t=%0t)", $time);
               sb_q.delete();
            end
         end
      end
   end

   initial begin
      rst = 1'b1; wr_en = 1'b0; weight_addr = '0; weight_data = '0;
      swap_req = 1'b0; rd_req = 1'b0; bias_addr = '0;
      do_reset();

      // Read before any swap: no valid, data stays 0.
      step(1'b0, 32'd0, 16'd0, 1'b0, 1'b1, 3'd2);
      idle();

      // Partial fill: swap must be ignored at 31 words, accepted at 32.
      fill_range(0, 30, 16'h100);
      step(1'b0, 32'd0, 16'd0, 1'b1, 1'b0, 3'd0);
      idle();
      fill_range(31, 31, 16'h100);
      idle();
      step(1'b0, 32'd0, 16'd0, 1'b1, 1'b0, 3'd0);
      idle();
      step(1'b0, 32'd0, 16'd0, 1'b0, 1'b1, 3'd3);
      chk("t1_bias_valid", {63'd0, bias_valid}, 64'd1);
      chk("t1_bias_data",  bias_data, 64'h010F_010E_010D_010C);
      idle();

      // Refill the other bank while reading the active one on alternate cycles.
      for (int i = 0; i < TOTAL; i++)
         step(1'b1, BASE + 32'(i), 16'h200 + 16'(i), 1'b0, (i % 2) == 0, 3'($urandom_range(0, 7)));
      step(1'b0, 32'd0, 16'd0, 1'b1, 1'b1, 3'($urandom_range(0, 7)));
      for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 16'd0, 1'b0, 1'b1, 3'($urandom_range(0, 7)));
      step(1'b0, 32'd0, 16'd0, 1'b0, 1'b1, 3'd0);
      chk("t3_bias_data", bias_data, 64'h0203_0202_0201_0200);
      idle();

      // Reset mid-fill, then a complete refill is required before a swap.
      do_reset();
      fill_range(0, 9, 16'h300);
      do_reset();
      step(1'b0, 32'd0, 16'd0, 1'b0, 1'b1, 3'd1);
      fill_range(0, 30, 16'h400);
      step(1'b0, 32'd0, 16'd0, 1'b1, 1'b1, 3'd0);
      fill_range(31, 31, 16'h400);
      step(1'b0, 32'd0, 16'd0, 1'b1, 1'b0, 3'd0);
      step(1'b0, 32'd0, 16'd0, 1'b0, 1'b1, 3'd7);

      // Out-of-window writes are dropped and do not advance the counter.
      do_reset();
      step(1'b1, BASE - 32'd1, 16'hDEAD, 1'b0, 1'b0, 3'd0);
      step(1'b1, BASE + 32'd32, 16'hBEEF, 1'b0, 1'b0, 3'd0);
      fill_range(1, 31, 16'h500);
      step(1'b0, 32'd0, 16'd0, 1'b1, 1'b0, 3'd0);
      fill_range(0, 0, 16'h500);
      step(1'b0, 32'd0, 16'd0, 1'b1, 1'b0, 3'd0);
      step(1'b0, 32'd0, 16'd0, 1'b0, 1'b1, 3'd0);
      step(1'b1, BASE + 32'd100, 16'h1234, 1'b0, 1'b1, 3'd7);

      // Randomised traffic around the window edges.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            step($urandom_range(0, 3) != 0,
                 BASE - 32'd2 + 32'($urandom_range(0, 37)),
                 16'($urandom),
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1) == 1,
                 3'($urandom_range(0, 7)));
         end
      end
      idle();
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
